elevator_scan_controller: RTL and testbench

Parametrised successor to the four-floor elevator controller: a single-car controller for `NUM_FLOORS` floors. It latches car and hall calls, serves them in SCAN order, continuing in the current direction while calls remain ahead and reversing otherwise. Door dwell and floor-to-floor travel times are programmable. It sits between the button/sensor front end and the motor/door drivers.

---
 rtl/elevator_pkg.sv | 23 ++
 rtl/elevator_request_latch.sv | 74 +++++++
 rtl/elevator_scan_controller.sv | 184 ++++++++++++++++++
 tb/tb_elevator_scan_controller.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared state/direction encodings and floor-ordering helper for the SCAN elevator controller.
// Pure declarations: no latency or backpressure of its own.
package elevator_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MOVE = 2'd1;
    localparam logic [1:0] ST_OPEN = 2'd2;

    localparam logic [1:0] DIR_NONE = 2'd0;
    localparam logic [1:0] DIR_UP   = 2'd1;
    localparam logic [1:0] DIR_DOWN = 2'd2;

    // True when floor idx lies strictly past base when travelling in dir.
    function automatic logic beyond(input logic [31:0] idx, input logic [31:0] base,
                                    input logic [1:0] dir);
        case (dir)
            DIR_UP:   return idx > base;
            DIR_DOWN: return idx < base;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/elevator_request_latch.sv
// Holds car/hall requests and reduces them to above/below/here flags relative to the car floor.
// Press-to-pending is 1 clock; set beats clear, and blocked presses are reported instead of latched.
module elevator_request_latch
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = 4,
    parameter int FLOOR_W    = $clog2(NUM_FLOORS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] car_call,
    input  logic [NUM_FLOORS-1:0] hall_up,
    input  logic [NUM_FLOORS-1:0] hall_down,
    input  logic [FLOOR_W-1:0]    floor,
    input  logic [NUM_FLOORS-1:0] clr_car,
    input  logic [NUM_FLOORS-1:0] clr_up,
    input  logic [NUM_FLOORS-1:0] clr_down,
    input  logic [NUM_FLOORS-1:0] blk_car,
    input  logic [NUM_FLOORS-1:0] blk_up,
    input  logic [NUM_FLOORS-1:0] blk_down,
    output logic [NUM_FLOORS-1:0] pend_car,
    output logic [NUM_FLOORS-1:0] pend_up,
    output logic [NUM_FLOORS-1:0] pend_down,
    output logic                  blocked_press,
    output logic                  above,
    output logic                  below,
    output logic                  here
);

    // No up call from the top floor, no down call from the bottom floor.
    localparam logic [NUM_FLOORS-1:0] UP_OK   = {1'b0, {(NUM_FLOORS-1){1'b1}}};
    localparam logic [NUM_FLOORS-1:0] DOWN_OK = {{(NUM_FLOORS-1){1'b1}}, 1'b0};

    logic [NUM_FLOORS-1:0] up_in;
    logic [NUM_FLOORS-1:0] down_in;
    logic [NUM_FLOORS-1:0] pend_any;
    logic [NUM_FLOORS-1:0] above_m;
    logic [NUM_FLOORS-1:0] below_m;
    logic [NUM_FLOORS-1:0] here_m;

    assign up_in   = hall_up & UP_OK;
    assign down_in = hall_down & DOWN_OK;

    assign blocked_press = |((car_call & blk_car) | (up_in & blk_up) | (down_in & blk_down));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_car  <= '0;
            pend_up   <= '0;
            pend_down <= '0;
        end else begin
            pend_car  <= (pend_car & ~clr_car) | (car_call & ~blk_car);
            pend_up   <= (pend_up & ~clr_up) | (up_in & ~blk_up);
            pend_down <= (pend_down & ~clr_down) | (down_in & ~blk_down);
        end
    end

    always_comb begin
        above_m = '0;
        below_m = '0;
        here_m  = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            above_m[i] = beyond(32'(i), 32'(floor), DIR_UP);
            below_m[i] = beyond(32'(i), 32'(floor), DIR_DOWN);
            here_m[i]  = (32'(i) == 32'(floor));
        end
    end

    assign pend_any = pend_car | pend_up | pend_down;
    assign above    = |(pend_any & above_m);
    assign below    = |(pend_any & below_m);
    assign here     = |(pend_any & here_m);

endmodule

// File: rtl/elevator_scan_controller.sv
// Single-car SCAN elevator: IDLE/MOVE/OPEN FSM with programmable travel and door-dwell timers.
// Requests latch in 1 clock; MOVE takes TRAVEL_CYCLES per floor; door holds open while obstructed.
module elevator_scan_controller
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS    = 4,
    parameter int FLOOR_W       = $clog2(NUM_FLOORS),
    parameter int DOOR_CYCLES   = 3,
    parameter int TRAVEL_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] car_call,
    input  logic [NUM_FLOORS-1:0] hall_up,
    input  logic [NUM_FLOORS-1:0] hall_down,
    input  logic                  door_open_req,
    input  logic                  door_close_req,
    input  logic                  door_sensor,
    output logic                  up,
    output logic                  down,
    output logic [FLOOR_W-1:0]    floor,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pend_car,
    output logic [NUM_FLOORS-1:0] pend_up,
    output logic [NUM_FLOORS-1:0] pend_down
);

    logic [1:0]            state, state_nxt;
    logic [1:0]            dir, dir_nxt;
    logic [CNT_W-1:0]      timer, timer_nxt, timer_inc;
    logic [FLOOR_W-1:0]    floor_nxt, f_next;
    logic [NUM_FLOORS-1:0] floor_oh, f_oh, beyond_m, pend_any;
    logic [NUM_FLOORS-1:0] clr_car, clr_up, clr_down;
    logic [NUM_FLOORS-1:0] blk_car, blk_up, blk_down;
    logic                  above, below, here, blocked_press;
    logic                  travel_done, door_done, beyond_next, at_end, stop, ahead;

    elevator_request_latch #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_latch (
        .clk           (clk),
        .reset         (reset),
        .car_call      (car_call),
        .hall_up       (hall_up),
        .hall_down     (hall_down),
        .floor         (floor),
        .clr_car       (clr_car),
        .clr_up        (clr_up),
        .clr_down      (clr_down),
        .blk_car       (blk_car),
        .blk_up        (blk_up),
        .blk_down      (blk_down),
        .pend_car      (pend_car),
        .pend_up       (pend_up),
        .pend_down     (pend_down),
        .blocked_press (blocked_press),
        .above         (above),
        .below         (below),
        .here          (here)
    );

    assign pend_any    = pend_car | pend_up | pend_down;
    assign timer_inc   = timer + 1'b1;
    assign travel_done = timer_inc >= CNT_W'(TRAVEL_CYCLES);
    assign door_done   = timer_inc >= CNT_W'(DOOR_CYCLES);
    assign f_next      = (dir == DIR_DOWN) ? floor - 1'b1 : floor + 1'b1;

    always_comb begin
        floor_oh = '0;
        f_oh     = '0;
        beyond_m = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            floor_oh[i] = (32'(i) == 32'(floor));
            f_oh[i]     = (32'(i) == 32'(f_next));
            beyond_m[i] = beyond(32'(i), 32'(f_next), dir);
        end
    end

    // Stop test is evaluated against the floor the car is arriving at.
    assign beyond_next = |(pend_any & beyond_m);
    assign at_end      = ((dir == DIR_UP) && (32'(f_next) == 32'(NUM_FLOORS - 1)))
                       || ((dir == DIR_DOWN) && (f_next == '0));
    assign stop        = at_end || !beyond_next || |(pend_car & f_oh)
                       || |(((dir == DIR_UP) ? pend_up : pend_down) & f_oh);
    assign ahead       = ((dir == DIR_UP) && above) || ((dir == DIR_DOWN) && below);

    // While the door is open, presses at this floor in the service direction only extend dwell.
    assign blk_car  = (state == ST_OPEN) ? floor_oh : '0;
    assign blk_up   = ((state == ST_OPEN) && (dir != DIR_DOWN)) ? floor_oh : '0;
    assign blk_down = ((state == ST_OPEN) && (dir != DIR_UP)) ? floor_oh : '0;

    always_comb begin
        state_nxt = state;
        dir_nxt   = dir;
        timer_nxt = timer;
        floor_nxt = floor;
        clr_car   = '0;
        clr_up    = '0;
        clr_down  = '0;
        case (state)
            ST_IDLE: begin
                timer_nxt = '0;
                if (here || door_open_req) begin
                    state_nxt = ST_OPEN;
                    clr_car   = floor_oh;
                    clr_up    = floor_oh;
                    clr_down  = floor_oh;
                end else if (above) begin
                    state_nxt = ST_MOVE;
                    dir_nxt   = DIR_UP;
                end else if (below) begin
                    state_nxt = ST_MOVE;
                    dir_nxt   = DIR_DOWN;
                end
            end
            ST_MOVE: begin
                if (travel_done) begin
                    floor_nxt = f_next;
                    timer_nxt = '0;
                    if (stop) begin
                        state_nxt = ST_OPEN;
                        clr_car   = f_oh;
                        if ((dir == DIR_UP) || !beyond_next)   clr_up   = f_oh;
                        if ((dir == DIR_DOWN) || !beyond_next) clr_down = f_oh;
                    end
                end else begin
                    timer_nxt = timer_inc;
                end
            end
            ST_OPEN: begin
                if (door_sensor || door_open_req || blocked_press) begin
                    timer_nxt = '0;
                end else if (door_done) begin
                    timer_nxt = '0;
                    if (ahead) begin
                        state_nxt = ST_MOVE;
                    end else if (above) begin
                        state_nxt = ST_MOVE;
                        dir_nxt   = DIR_UP;
                    end else if (below) begin
                        state_nxt = ST_MOVE;
                        dir_nxt   = DIR_DOWN;
                    end else begin
                        state_nxt = ST_IDLE;
                        dir_nxt   = DIR_NONE;
                    end
                end else if (door_close_req) begin
                    timer_nxt = CNT_W'(DOOR_CYCLES - 1);
                end else begin
                    timer_nxt = timer_inc;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                dir_nxt   = DIR_NONE;
                timer_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            dir   <= DIR_NONE;
            timer <= '0;
            floor <= '0;
        end else begin
            state <= state_nxt;
            dir   <= dir_nxt;
            timer <= timer_nxt;
            floor <= floor_nxt;
        end
    end

    assign up        = (state == ST_MOVE) && (dir == DIR_UP);
    assign down      = (state == ST_MOVE) && (dir == DIR_DOWN);
    assign door_open = (state == ST_OPEN);

    ap_motion_door_excl: assert property (@(posedge clk) disable iff (!reset)
        $onehot0({up, down, door_open}));

endmodule

// File: tb/tb_elevator_scan_controller.sv
// Directed bench: 4-floor car driven from a vector table, 8-floor car for boundary cases.
module tb_elevator_scan_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] car_call, hall_up, hall_down;
    logic       door_open_req, door_close_req, door_sensor;
    logic       up, down, door_open;
    logic [1:0] floor;
    logic [3:0] pend_car, pend_up, pend_down;

    logic [7:0] car8, hu8, hd8;
    logic       up8, down8, door8;
    logic [2:0] floor8;
    logic [7:0] pc8, pu8, pd8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    elevator_scan_controller #(.NUM_FLOORS(4)) dut4 (
        .clk            (clk),
        .reset          (reset),
        .car_call       (car_call),
        .hall_up        (hall_up),
        .hall_down      (hall_down),
        .door_open_req  (door_open_req),
        .door_close_req (door_close_req),
        .door_sensor    (door_sensor),
        .up             (up),
        .down           (down),
        .floor          (floor),
        .door_open      (door_open),
        .pend_car       (pend_car),
        .pend_up        (pend_up),
        .pend_down      (pend_down)
    );

    elevator_scan_controller #(.NUM_FLOORS(8)) dut8 (
        .clk            (clk),
        .reset          (reset),
        .car_call       (car8),
        .hall_up        (hu8),
        .hall_down      (hd8),
        .door_open_req  (1'b0),
        .door_close_req (1'b0),
        .door_sensor    (1'b0),
        .up             (up8),
        .down           (down8),
        .floor          (floor8),
        .door_open      (door8),
        .pend_car       (pc8),
        .pend_up        (pu8),
        .pend_down      (pd8)
    );

    typedef struct {
        logic       rst;
        int         hold;
        logic [3:0] car, hu, hd;
        logic       o, c, s;
        logic       eu, ed;
        logic [1:0] ef;
        logic       edoor;
        logic [3:0] epc, epu, epd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input int hold, input logic [3:0] car, hu, hd,
                       input logic o, c, s, input logic eu, ed, input logic [1:0] ef,
                       input logic edoor, input logic [3:0] epc, epu, epd);
        vecs.push_back(vec_t'{rst, hold, car, hu, hd, o, c, s, eu, ed, ef, edoor, epc, epu, epd});
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        car_call = '0; hall_up = '0; hall_down = '0;
        door_open_req = 1'b0; door_close_req = 1'b0; door_sensor = 1'b0;
        car8 = '0; hu8 = '0; hd8 = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    function automatic logic [31:0] obs4();
        return 32'({up, down, floor, door_open, pend_car, pend_up, pend_down});
    endfunction

    initial begin
        vec_t v;
        clear_inputs();
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("reset_state", obs4(), 32'h0);
        reset = 1'b1;

        // rst hold car hu hd o c s | up dn fl door pc pu pd
        // Basic trip 0 -> 3
        add(0, 1, 4'h8, 4'h0, 4'h0, 0, 0, 0,  0, 0, 2'd0, 0, 4'h8, 4'h0, 4'h0);
        add(0, 1, 4'h0, 4'h0, 4'h0, 0, 0, 0,  1, 0, 2'd0, 0, 4'h8, 4'h0, 4'h0);
        add(0, 3, 4'h0, 4'h0, 4'h0, 0, 0, 0,  1, 0, 2'd0, 0, 4'h8, 4'h0, 4'h0);
        add(0, 1, 4'h0, 4'h0, 4'h0, 0, 0, 0,  1, 0, 2'd1, 0, 4'h8, 4'h0, 4'h0);
        add(0, 8, 4'h0, 4'h0, 4'h0, 0, 0, 0,  0, 0, 2'd3, 1, 4'h0, 4'h0, 4'h0);
        add(0, 2, 4'h0, 4'h0, 4'h0, 0, 0, 0,  0, 0, 2'd3, 1, 4'h0, 4'h0, 4'h0);
        add(0, 1, 4'h0, 4'h0, 4'h0, 0, 0, 0,  0, 0, 2'd3, 0, 4'h0, 4'h0, 4'h0);
        add(0, 2, 4'h0, 4'h0, 4'h0, 0, 0, 0,  0, 0, 2'd3, 0, 4'h0, 4'h0, 4'h0);
        // SCAN: car 3 + hall down 1, pass 1 going up, serve it on the way down
        add(1, 1, 4'h8, 4'h0, 4'h2, 0, 0, 0,  0, 0, 2'd0, 0, 4'h8, 4'h0, 4'h2);
        add(0, 1, 4'h0, 4'h0, 4'h0, 0, 0, 0,  1, 0, 2'd0, 0, 4'h8, 4'h0, 4'h2);
        add(0, 4, 4'h0, 4'h0, 4'h0, 0, 0, 0,  1, 0, 2'd1, 0, 4'h8, 4'h0, 4'h2);
        add(0, 8, 4'h0, 4'h0, 4'h0, 0, 0, 0,  0, 0, 2'd3, 1, 4'h0, 4'h0, 4'h2);
        add(0, 3, 4'h0, 4'h0, 4'h0, 0, 0, 0,  0, 1, 2'd3, 0, 4'h0, 4'h0, 4'h2);
        add(0, 4, 4'h0, 4'h0, 4'h0, 0, 0, 0,  0, 1, 2'd2, 0, 4'h0, 4'h0, 4'h2);
        add(0, 3, 4'h0, 4'h0, 4'h0, 0, 0, 0,  0, 1, 2'd2, 0, 4'h0, 4'h0, 4'h2);
        add(0, 1, 4'h0, 4'h0, 4'h0, 0, 0, 0,  0, 0, 2'd1, 1, 4'h0, 4'h0, 4'h0);
        add(0, 3, 4'h0, 4'h0, 4'h0, 0, 0, 0,  0, 0, 2'd1, 0, 4'h0, 4'h0, 4'h0);
        // Door sensor held 5 clocks at floor 1
        add(1, 1, 4'h2, 4'h0, 4'h0, 0, 0, 0,  0, 0, 2'd0, 0, 4'h2, 4'h0, 4'h0);
        add(0, 5, 4'h0, 4'h0, 4'h0, 0, 0, 0,  0, 0, 2'd1, 1, 4'h0, 4'h0, 4'h0);
        add(0, 5, 4'h0, 4'h0, 4'h0, 0, 0, 1,  0, 0, 2'd1, 1, 4'h0, 4'h0, 4'h0);
        add(0, 2, 4'h0, 4'h0, 4'h0, 0, 0, 0,  0, 0, 2'd1, 1, 4'h0, 4'h0, 4'h0);
        add(0, 1, 4'h0, 4'h0, 4'h0, 0, 0, 0,  0, 0, 2'd1, 0, 4'h0, 4'h0, 4'h0);
        // Close button in first OPEN cycle, then open+close together, then open in IDLE
        add(1, 1, 4'h2, 4'h0, 4'h0, 0, 0, 0,  0, 0, 2'd0, 0, 4'h2, 4'h0, 4'h0);
        add(0, 5, 4'h0, 4'h0, 4'h0, 0, 0, 0,  0, 0, 2'd1, 1, 4'h0, 4'h0, 4'h0);
        add(0, 1, 4'h0, 4'h0, 4'h0, 0, 1, 0,  0, 0, 2'd1, 1, 4'h0, 4'h0, 4'h0);
        add(0, 1, 4'h0, 4'h0, 4'h0, 0, 0, 0,  0, 0, 2'd1, 0, 4'h0, 4'h0, 4'h0);
        add(0, 1, 4'h4, 4'h0, 4'h0, 0, 0, 0,  0, 0, 2'd1, 0, 4'h4, 4'h0, 4'h0);
        add(0, 5, 4'h0, 4'h0, 4'h0, 0, 0, 0,  0, 0, 2'd2, 1, 4'h0, 4'h0, 4'h0);
        add(0, 1, 4'h0, 4'h0, 4'h0, 1, 1, 0,  0, 0, 2'd2, 1, 4'h0, 4'h0, 4'h0);
        add(0, 2, 4'h0, 4'h0, 4'h0, 0, 0, 0,  0, 0, 2'd2, 1, 4'h0, 4'h0, 4'h0);
        add(0, 1, 4'h0, 4'h0, 4'h0, 0, 0, 0,  0, 0, 2'd2, 0, 4'h0, 4'h0, 4'h0);
        add(0, 1, 4'h0, 4'h0, 4'h0, 1, 0, 0,  0, 0, 2'd2, 1, 4'h0, 4'h0, 4'h0);
        add(0, 2, 4'h0, 4'h0, 4'h0, 0, 0, 0,  0, 0, 2'd2, 1, 4'h0, 4'h0, 4'h0);
        add(0, 1, 4'h0, 4'h0, 4'h0, 0, 0, 0,  0, 0, 2'd2, 0, 4'h0, 4'h0, 4'h0);
        // Ignored hall bits: up at top floor, down at bottom floor
        add(0, 1, 4'h0, 4'h8, 4'h1, 0, 0, 0,  0, 0, 2'd2, 0, 4'h0, 4'h0, 4'h0);
        add(0, 2, 4'h0, 4'h0, 4'h0, 0, 0, 0,  0, 0, 2'd2, 0, 4'h0, 4'h0, 4'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            if (v.rst) do_reset();
            car_call = v.car; hall_up = v.hu; hall_down = v.hd;
            door_open_req = v.o; door_close_req = v.c; door_sensor = v.s;
            repeat (v.hold) @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), obs4(),
                  32'({v.eu, v.ed, v.ef, v.edoor, v.epc, v.epu, v.epd}));
            clear_inputs();
        end

        // 8 floors: ignored hall bits, open-at-current-floor, press during OPEN, top-floor trip
        do_reset();
        hu8 = 8'h80; hd8 = 8'h01;
        @(posedge clk); #1;
        check("b8_pend_up_ignored", 32'(pu8), 32'h0);
        check("b8_pend_down_ignored", 32'(pd8), 32'h0);
        clear_inputs();
        @(posedge clk); #1;
        check("b8_still_idle", 32'({up8, down8, door8}), 32'h0);
        car8 = 8'h01;
        @(posedge clk); #1;
        check("b8_here_latched", 32'({door8, pc8}), 32'h001);
        clear_inputs();
        @(posedge clk); #1;
        check("b8_here_opens", 32'({door8, pc8}), 32'h100);
        car8 = 8'h01;
        @(posedge clk); #1;
        check("b8_open_press_not_latched", 32'({door8, pc8}), 32'h100);
        clear_inputs();
        repeat (2) @(posedge clk); #1;
        check("b8_press_extends_dwell", 32'(door8), 32'h1);
        @(posedge clk); #1;
        check("b8_door_closed", 32'(door8), 32'h0);
        car8 = 8'h80;
        @(posedge clk); #1;
        clear_inputs();
        repeat (28) @(posedge clk); #1;
        check("b8_floor6_moving", 32'({up8, floor8, door8}), 32'({1'b1, 3'd6, 1'b0}));
        @(posedge clk); #1;
        check("b8_top_stop", 32'({up8, floor8, door8, pc8}), 32'({1'b0, 3'd7, 1'b1, 8'h00}));

        // Asynchronous reset in the middle of a move at floor 2
        do_reset();
        car_call = 4'h8; hall_down = 4'h2;
        @(posedge clk); #1;
        clear_inputs();
        repeat (10) @(posedge clk); #1;
        check("mid_move_floor2", obs4(), 32'({1'b1, 1'b0, 2'd2, 1'b0, 4'h8, 4'h0, 4'h2}));
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_outputs", obs4(), 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
